// File: rtl/nibble_tx_if.sv
// nibble_tx_if: valid/ready word handshake between the FIFO read side and the transmitter
interface nibble_tx_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    modport master (output in_data, output in_valid, input in_ready);
    modport slave (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/nibble_tx.sv
// nibble_tx: framed serial transmitter (start, data LSB first, optional parity, stop)
module nibble_tx #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    nibble_tx_if.slave in_if,
    output logic       tx_out,
    output logic       busy,
    output logic       frame_done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state, state_nx;
    logic [CW-1:0]         baud, baud_nx;
    logic [BW-1:0]         bitc, bitc_nx;
    logic [DATA_WIDTH-1:0] shreg, shreg_nx;
    logic                  par, par_nx, tx_nx, done_nx, last, hs;
    assign last = baud == BAUD_LAST;
    // accept in IDLE or on the final stop cycle so frames can run back to back
    assign in_if.in_ready = rst && (state == IDLE || (state == STOP && last));
    assign hs = in_if.in_valid && in_if.in_ready;
    // next state, counters, shift register and the registered-output next values
    always_comb begin
        state_nx = state;
        baud_nx  = (state == IDLE || last) ? '0 : baud + 1'b1;
        bitc_nx  = bitc;
        shreg_nx = shreg;
        par_nx   = par;
        case (state)
            START:   if (last) begin
                         state_nx = DATA;
                         bitc_nx  = '0;
                     end
            DATA:    if (last) begin
                         shreg_nx = shreg >> 1;
                         if (bitc == BIT_LAST) state_nx = PARITY_EN != 0 ? PARITY : STOP;
                         else bitc_nx = bitc + 1'b1;
                     end
            PARITY:  if (last) state_nx = STOP;
            STOP:    if (last) state_nx = IDLE;
            default: ;
        endcase
        if (hs) begin
            shreg_nx = in_if.in_data;
            par_nx   = (^in_if.in_data) ^ (PARITY_ODD != 0);
            state_nx = START;
        end
        tx_nx   = state_nx == START ? 1'b0 : state_nx == DATA ? shreg_nx[0] : state_nx == PARITY ? par_nx : 1'b1;
        done_nx = state_nx == STOP && baud_nx == BAUD_LAST;
    end
    // state register; outputs registered from their next values so they line up with the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            baud       <= '0;
            bitc       <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            baud       <= baud_nx;
            bitc       <= bitc_nx;
            shreg      <= shreg_nx;
            par        <= par_nx;
            tx_out     <= tx_nx;
            busy       <= state_nx != IDLE;
            frame_done <= done_nx;
        end
    end
endmodule

// File: tb/tb_nibble_tx.sv
// tb_nibble_tx: frame-position model of four nibble_tx variants plus directed literal frames
module tb_nibble_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    localparam int CPB [4] = '{4, 4, 4, 1};
    localparam int PEN [4] = '{1, 1, 0, 1};
    localparam int PODD [4] = '{0, 1, 0, 0};
    logic [3:0] dat [4];
    logic vld [4];
    logic rdy [4];
    logic tx [4];
    logic busy [4];
    logic done [4];
    nibble_tx_if #(.DATA_WIDTH(4)) i0 ();
    nibble_tx_if #(.DATA_WIDTH(4)) i1 ();
    nibble_tx_if #(.DATA_WIDTH(4)) i2 ();
    nibble_tx_if #(.DATA_WIDTH(4)) i3 ();
    assign i0.in_data = dat[0];
    assign i1.in_data = dat[1];
    assign i2.in_data = dat[2];
    assign i3.in_data = dat[3];
    assign i0.in_valid = vld[0];
    assign i1.in_valid = vld[1];
    assign i2.in_valid = vld[2];
    assign i3.in_valid = vld[3];
    assign rdy[0] = i0.in_ready;
    assign rdy[1] = i1.in_ready;
    assign rdy[2] = i2.in_ready;
    assign rdy[3] = i3.in_ready;
    nibble_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .in_if(i0), .tx_out(tx[0]), .busy(busy[0]), .frame_done(done[0]));
    nibble_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
        .clk(clk), .rst(rst), .in_if(i1), .tx_out(tx[1]), .busy(busy[1]), .frame_done(done[1]));
    nibble_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u2 (
        .clk(clk), .rst(rst), .in_if(i2), .tx_out(tx[2]), .busy(busy[2]), .frame_done(done[2]));
    nibble_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) u3 (
        .clk(clk), .rst(rst), .in_if(i3), .tx_out(tx[3]), .busy(busy[3]), .frame_done(done[3]));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pos [4];
    logic [3:0] word [4];
    bit txl [4][0:2047];
    bit dnl [4][0:2047];
    bit bsl [4][0:2047];

    function automatic int flen(int d);
        return (6 + PEN[d]) * CPB[d];
    endfunction

    // bit i of a frame: 0 start, 1..4 data LSB first, 5 parity when enabled, else stop
    function automatic logic fbit(int d, logic [3:0] w, int i);
        if (i == 0) return 1'b0;
        if (i <= 4) return w[i-1];
        if (PEN[d] != 0 && i == 5) return (^w) ^ (PODD[d] != 0);
        return 1'b1;
    endfunction

    function automatic logic m_tx(int d);
        return pos[d] < 0 ? 1'b1 : fbit(d, word[d], pos[d] / CPB[d]);
    endfunction

    function automatic logic m_ready(int d);
        return rst && (pos[d] < 0 || pos[d] == flen(d) - 1);
    endfunction

    task automatic chk(string nm, int d, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0b want=%0b", nm, d, cyc, act, exp);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // model: position within the current frame, -1 when idle
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 4; d++) pos[d] <= -1;
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (vld[d] && m_ready(d)) begin
                    word[d] <= dat[d];
                    pos[d] <= 0;
                end else if (pos[d] >= 0) begin
                    pos[d] <= pos[d] == flen(d) - 1 ? -1 : pos[d] + 1;
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // every cycle: log outputs and compare all four DUTs against the model
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            txl[d][cyc] <= tx[d];
            dnl[d][cyc] <= done[d];
            bsl[d][cyc] <= busy[d];
            chk("tx", d, tx[d], m_tx(d));
            chk("busy", d, busy[d], pos[d] >= 0);
            chk("frame_done", d, done[d], pos[d] == flen(d) - 1);
            chk("in_ready", d, rdy[d], m_ready(d));
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // present a word, wait (bounded) for ready, return the handshake cycle index
    task automatic send(int d, logic [3:0] w, logic keep, output int k);
        int n = 0;
        vld[d] = 1'b1;
        dat[d] = w;
        while (!rdy[d] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 200) chk_int("ready_timeout", n, 0);
        @(posedge clk);
        #1;
        k = cyc;
        vld[d] = keep;
    endtask

    // literal frame check: every cycle of every bit, one frame_done at the end, busy for the frame length
    task automatic chk_frame(string nm, int d, int k, int nb, logic [15:0] bits, logic tail_idle);
        int cpb = CPB[d];
        int len = nb * CPB[d];
        int nd = 0;
        int nbz = 0;
        for (int i = 0; i < nb; i++)
            for (int c = 0; c < cpb; c++) chk(nm, d, txl[d][k + i * cpb + c], bits[i]);
        for (int j = k; j < k + len; j++) begin
            nd += int'(dnl[d][j]);
            nbz += int'(bsl[d][j]);
        end
        chk_int({nm, "_done_count"}, nd, 1);
        chk({nm, "_done_last"}, d, dnl[d][k + len - 1], 1'b1);
        chk_int({nm, "_busy_len"}, nbz, len);
        if (tail_idle) chk({nm, "_idle_after"}, d, bsl[d][k + len], 1'b0);
    endtask

    initial begin
        int k, k2, nd;
        for (int d = 0; d < 4; d++) begin
            vld[d] = 1'b0;
            dat[d] = 4'b0000;
        end
        wait_cyc(3);
        chk("rst_tx", 0, tx[0], 1'b1);
        chk("rst_busy", 0, busy[0], 1'b0);
        chk("rst_done", 0, done[0], 1'b0);
        chk("rst_ready", 0, rdy[0], 1'b0);
        rst = 1'b1;
        #1;
        chk("release_ready", 0, rdy[0], 1'b1);

        send(0, 4'b0101, 1'b0, k);
        wait_cyc(31);
        chk_frame("single", 0, k, 7, 16'b1001010, 1'b1);

        send(0, 4'b0111, 1'b0, k);
        wait_cyc(31);
        chk_frame("parity_even", 0, k, 7, 16'b1101110, 1'b1);
        send(1, 4'b0111, 1'b0, k);
        wait_cyc(31);
        chk_frame("parity_odd", 1, k, 7, 16'b1001110, 1'b1);
        send(2, 4'b0111, 1'b0, k);
        wait_cyc(27);
        chk_frame("no_parity", 2, k, 6, 16'b101110, 1'b1);

        send(0, 4'b0101, 1'b1, k);
        send(0, 4'b1101, 1'b0, k2);
        chk_int("b2b_spacing", k2 - k, 28);
        wait_cyc(31);
        chk_frame("b2b_first", 0, k, 7, 16'b1001010, 1'b0);
        chk_frame("b2b_second", 0, k2, 7, 16'b1111010, 1'b1);

        send(0, 4'b0110, 1'b0, k);
        for (int i = 0; i < 10; i++) begin
            dat[0] = 4'b1111;
            vld[0] = ~vld[0];
            wait_cyc(1);
        end
        vld[0] = 1'b0;
        wait_cyc(21);
        chk_frame("stall", 0, k, 7, 16'b1001100, 1'b1);

        send(0, 4'b0101, 1'b0, k);
        wait_cyc(12);
        rst = 1'b0;
        #1;
        chk("midrst_tx", 0, tx[0], 1'b1);
        chk("midrst_busy", 0, busy[0], 1'b0);
        chk("midrst_ready", 0, rdy[0], 1'b0);
        wait_cyc(2);
        nd = 0;
        for (int j = k; j < cyc; j++) nd += int'(dnl[0][j]);
        chk_int("midrst_no_done", nd, 0);
        rst = 1'b1;
        #1;
        chk("midrst_release_ready", 0, rdy[0], 1'b1);
        send(0, 4'b1001, 1'b0, k);
        wait_cyc(31);
        chk_frame("after_reset", 0, k, 7, 16'b1010010, 1'b1);

        send(3, 4'b0001, 1'b0, k);
        wait_cyc(10);
        chk_frame("fast", 3, k, 7, 16'b1100010, 1'b1);

        wait_cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
